control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/inst_decode.sv | 46 ++++
 rtl/control_unit.sv | 128 ++++++++++++
 tb/tb_control_unit.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared control/datapath definitions: opcodes, one-hot datapath ops, FSM state
// encoding and the decoded-instruction record.
package cpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_RSH   = 4'd2;
  localparam logic [3:0] OP_LSH   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_LOAD  = 4'd5;
  localparam logic [3:0] OP_STORE = 4'd6;
  localparam logic [3:0] OP_HALT  = 4'd7;

  localparam logic [5:0] DP_NONE  = 6'b000000;
  localparam logic [5:0] DP_ADD   = 6'b000001;
  localparam logic [5:0] DP_RSH   = 6'b000010;
  localparam logic [5:0] DP_LSH   = 6'b000100;
  localparam logic [5:0] DP_AND   = 6'b001000;
  localparam logic [5:0] DP_LOAD  = 6'b010000;
  localparam logic [5:0] DP_STORE = 6'b100000;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_READ, S_EXEC, S_WB, S_HALTED
  } state_e;

  // short: instruction finishes in DECODE (NOP, HALT, illegal)
  typedef struct packed {
    logic [5:0] dp;
    logic       rd1;
    logic       rd2;
    logic       wb;
    logic       illegal;
    logic       short;
    logic       halt;
  } dec_t;

endpackage

// File: rtl/inst_decode.sv
// Pure combinational opcode decode into datapath op and register-file strobe enables.
module inst_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  output dec_t       dec
);

  always_comb begin
    dec     = '0;
    dec.rd1 = 1'b1;
    dec.rd2 = 1'b1;
    dec.wb  = 1'b1;
    case (opcode)
      OP_ADD:   dec.dp = DP_ADD;
      OP_RSH:   dec.dp = DP_RSH;
      OP_LSH:   dec.dp = DP_LSH;
      OP_AND:   dec.dp = DP_AND;
      OP_LOAD: begin
        dec.dp  = DP_LOAD;
        dec.rd1 = 1'b0;
        dec.rd2 = 1'b0;
      end
      OP_STORE: begin
        dec.dp  = DP_STORE;
        dec.rd2 = 1'b0;
        dec.wb  = 1'b0;
      end
      OP_NOP, OP_HALT: begin
        dec.rd1   = 1'b0;
        dec.rd2   = 1'b0;
        dec.wb    = 1'b0;
        dec.short = 1'b1;
        dec.halt  = (opcode == OP_HALT);
      end
      default: begin
        dec.rd1     = 1'b0;
        dec.rd2     = 1'b0;
        dec.wb      = 1'b0;
        dec.short   = 1'b1;
        dec.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle instruction sequencer: IDLE -> DECODE -> READ -> EXEC -> WB.
// Outputs decode only from the state and latched-instruction registers.
module control_unit
  import cpu_pkg::*;
#(
  parameter int INST_W = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INST_W-1:0] inst,
  input  logic              inst_valid,
  output logic              inst_ready,
  output logic [5:0]        dp_ctrl,
  output logic [ADDR_W-1:0] addr1,
  output logic [ADDR_W-1:0] addr2,
  output logic              rd1,
  output logic              rd2,
  output logic              wr1,
  output logic              illegal,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  state_e            state_q, state_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic              ready_q, ready_d;
  dec_t              dec;

  logic [ADDR_W-1:0] f_rd, f_rs1, f_rs2;
  assign f_rd  = inst_q[8 +: ADDR_W];
  assign f_rs1 = inst_q[4 +: ADDR_W];
  assign f_rs2 = inst_q[0 +: ADDR_W];

  inst_decode u_dec (
    .opcode (inst_q[15:12]),
    .dec    (dec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      inst_q    <= '0;
      retired_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
      ready_q   <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    inst_d    = inst_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (inst_valid && ready_q) begin
          inst_d  = inst;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec.short) begin
          state_d = dec.halt ? S_HALTED : S_IDLE;
          if (!dec.illegal) retired_d = retired_q + CNT_W'(1);
        end else begin
          state_d = S_READ;
        end
      end
      S_READ: state_d = S_EXEC;
      S_EXEC: begin
        if (dec.wb) begin
          state_d = S_WB;
        end else begin
          state_d   = S_IDLE;
          retired_d = retired_q + CNT_W'(1);
        end
      end
      S_WB: begin
        state_d   = S_IDLE;
        retired_d = retired_q + CNT_W'(1);
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
    // Registered so ready stays low through reset and rises on the first edge after it.
    ready_d = (state_d == S_IDLE);
  end

  always_comb begin
    dp_ctrl = DP_NONE;
    addr1   = '0;
    addr2   = '0;
    rd1     = 1'b0;
    rd2     = 1'b0;
    wr1     = 1'b0;
    illegal = 1'b0;
    case (state_q)
      S_DECODE: illegal = dec.illegal;
      S_READ: begin
        addr1 = f_rs1;
        addr2 = f_rs2;
        rd1   = dec.rd1;
        rd2   = dec.rd2;
      end
      S_EXEC: begin
        addr1   = f_rs1;
        addr2   = f_rs2;
        dp_ctrl = dec.dp;
      end
      S_WB: begin
        addr1 = f_rd;
        wr1   = 1'b1;
      end
      default: ;
    endcase
  end

  assign inst_ready = ready_q;
  assign halted     = (state_q == S_HALTED);
  assign retired    = retired_q;

endmodule

// File: tb/tb_control_unit.sv
// Table-driven bench for control_unit: per-cycle expected outputs are queued by the
// driver and compared on the falling edge by a monitor.
module tb_control_unit;

  logic        clk, rst;
  logic [15:0] inst;
  logic        inst_valid;
  logic        inst_ready, rd1, rd2, wr1, illegal, halted;
  logic [5:0]  dp_ctrl;
  logic [3:0]  addr1, addr2;
  logic [7:0]  retired;

  control_unit dut (
    .clk(clk), .rst(rst), .inst(inst), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .dp_ctrl(dp_ctrl), .addr1(addr1), .addr2(addr2),
    .rd1(rd1), .rd2(rd2), .wr1(wr1), .illegal(illegal), .halted(halted),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rdy;
    logic [5:0] dp;
    logic [3:0] a1;
    logic [3:0] a2;
    logic       rd1, rd2, wr1, ill, hlt;
    logic [7:0] ret;
  } obs_t;

  typedef struct {
    obs_t  o;
    string tag;
  } sb_t;

  typedef struct {
    string       name;
    logic [15:0] inst;
    logic [5:0]  dp;
    logic        rd1, rd2, wb, ill, lng;
  } vec_t;

  obs_t       cur;
  sb_t        sb[$];
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] cnt;

  assign cur = {inst_ready, dp_ctrl, addr1, addr2, rd1, rd2, wr1, illegal, halted, retired};

  task automatic check(string name, obs_t got, obs_t exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got rdy=%b dp=%b a1=%0d a2=%0d rd=%b%b wr=%b ill=%b hlt=%b ret=%0d | want rdy=%b dp=%b a1=%0d a2=%0d rd=%b%b wr=%b ill=%b hlt=%b ret=%0d",
               name, got.rdy, got.dp, got.a1, got.a2, got.rd1, got.rd2, got.wr1, got.ill, got.hlt, got.ret,
               exp.rdy, exp.dp, exp.a1, exp.a2, exp.rd1, exp.rd2, exp.wr1, exp.ill, exp.hlt, exp.ret);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t e;
      e = sb.pop_front();
      check(e.tag, cur, e.o);
    end
  end

  function automatic obs_t mk(logic rdy, logic [5:0] dp, logic [3:0] a1, logic [3:0] a2,
                              logic r1, logic r2, logic w, logic il, logic h);
    obs_t o;
    o.rdy = rdy; o.dp = dp; o.a1 = a1; o.a2 = a2;
    o.rd1 = r1; o.rd2 = r2; o.wr1 = w; o.ill = il; o.hlt = h;
    o.ret = cnt;
    return o;
  endfunction

  // Expectation describes the outputs for the cycle that begins at this edge.
  task automatic step(string tag, obs_t e);
    sb_t s;
    @(posedge clk);
    #1;
    s.o = e;
    s.tag = tag;
    sb.push_back(s);
  endtask

  task automatic run_vec(vec_t v);
    logic [3:0] f_rd, f_rs1, f_rs2;
    f_rd  = v.inst[11:8];
    f_rs1 = v.inst[7:4];
    f_rs2 = v.inst[3:0];
    step({v.name, " idle"}, mk(1, 6'b0, 4'd0, 4'd0, 0, 0, 0, 0, 0));
    inst_valid = 1'b1;
    inst = v.inst;
    step({v.name, " decode"}, mk(0, 6'b0, 4'd0, 4'd0, 0, 0, 0, v.ill, 0));
    inst_valid = 1'b0;
    inst = 16'($urandom);
    if (v.lng) begin
      step({v.name, " read"}, mk(0, 6'b0, f_rs1, f_rs2, v.rd1, v.rd2, 0, 0, 0));
      step({v.name, " exec"}, mk(0, v.dp, f_rs1, f_rs2, 0, 0, 0, 0, 0));
      if (v.wb) step({v.name, " wb"}, mk(0, 6'b0, f_rd, 4'd0, 0, 0, 1, 0, 0));
    end
    if (!v.ill) cnt = cnt + 8'd1;
  endtask

  // Reset applied mid-cycle, away from any edge; outputs must clear immediately.
  task automatic do_reset(string tag);
    @(negedge clk);
    #1;
    rst = 1'b1;
    inst_valid = 1'b0;
    #1;
    check({tag, " async"}, cur, '0);
    @(posedge clk);
    #1;
    check({tag, " held over edge"}, cur, '0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check({tag, " released pre-edge"}, cur, '0);
    cnt = 8'd0;
  endtask

  vec_t vecs[10];
  vec_t nop_v, add_v;

  initial begin
    vecs[0] = '{"ADD",     16'h1312, 6'b000001, 1, 1, 1, 0, 1};
    vecs[1] = '{"RSHIFT",  16'h2a5c, 6'b000010, 1, 1, 1, 0, 1};
    vecs[2] = '{"LSHIFT",  16'h3e01, 6'b000100, 1, 1, 1, 0, 1};
    vecs[3] = '{"AND",     16'h4512, 6'b001000, 1, 1, 1, 0, 1};
    vecs[4] = '{"STORE",   16'h6070, 6'b100000, 1, 0, 0, 0, 1};
    vecs[5] = '{"LOAD",    16'h59ab, 6'b010000, 0, 0, 1, 0, 1};
    vecs[6] = '{"NOP",     16'h0fff, 6'b000000, 0, 0, 0, 0, 0};
    vecs[7] = '{"ILL_F",   16'hF000, 6'b000000, 0, 0, 0, 1, 0};
    vecs[8] = '{"ILL_8",   16'h8123, 6'b000000, 0, 0, 0, 1, 0};
    vecs[9] = '{"ADD2",    16'h1fed, 6'b000001, 1, 1, 1, 0, 1};
    nop_v   = '{"WRAPNOP", 16'h0000, 6'b000000, 0, 0, 0, 0, 0};
    add_v   = '{"ABORT",   16'h1312, 6'b000001, 1, 1, 1, 0, 1};

    rst = 1'b1;
    inst = 16'h0;
    inst_valid = 1'b0;
    cnt = 8'd0;
    #1;
    check("reset state", cur, '0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("reset release pre-edge", cur, '0);

    foreach (vecs[i]) run_vec(vecs[i]);
    step("post-table idle", mk(1, 6'b0, 4'd0, 4'd0, 0, 0, 0, 0, 0));

    // ADD interrupted by reset during EXEC: no write-back, counter cleared.
    step("abort idle", mk(1, 6'b0, 4'd0, 4'd0, 0, 0, 0, 0, 0));
    inst_valid = 1'b1;
    inst = add_v.inst;
    step("abort decode", mk(0, 6'b0, 4'd0, 4'd0, 0, 0, 0, 0, 0));
    inst_valid = 1'b0;
    step("abort read", mk(0, 6'b0, 4'd1, 4'd2, 1, 1, 0, 0, 0));
    step("abort exec", mk(0, 6'b000001, 4'd1, 4'd2, 0, 0, 0, 0, 0));
    do_reset("abort rst");
    step("abort recovered", mk(1, 6'b0, 4'd0, 4'd0, 0, 0, 0, 0, 0));

    // HALT: stays halted under a persistent offer until reset.
    step("halt idle", mk(1, 6'b0, 4'd0, 4'd0, 0, 0, 0, 0, 0));
    inst_valid = 1'b1;
    inst = 16'h7000;
    step("halt decode", mk(0, 6'b0, 4'd0, 4'd0, 0, 0, 0, 0, 0));
    inst = 16'h1312;
    cnt = cnt + 8'd1;
    for (int k = 0; k < 20; k++) step("halted", mk(0, 6'b0, 4'd0, 4'd0, 0, 0, 0, 0, 1));
    do_reset("halt rst");
    step("halt recovered", mk(1, 6'b0, 4'd0, 4'd0, 0, 0, 0, 0, 0));

    for (int k = 0; k < 256; k++) run_vec(nop_v);
    step("wrap idle", mk(1, 6'b0, 4'd0, 4'd0, 0, 0, 0, 0, 0));
    @(negedge clk);
    #1;
    n_chk++;
    if (retired !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap: retired=%0d want 0", retired);
    end

    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard drain: %0d left, want 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
